// File: rtl/acq_sequencer.sv
// Acquisition sequencer: decodes ASCII PIO commands, owns trigger configuration,
// and steps IDLE -> HOLD -> WAIT_TRIG -> CAPTURE -> READY for one DEPTH-sample waveform.
module acq_sequencer #(
  parameter int DEPTH     = 1000,
  parameter int ADDR_W    = 10,
  parameter int HOLDOFF   = 100,
  parameter int TIMEOUT_W = 24,
  parameter int TIMEOUT   = 16777215
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        cmd,
  input  logic              trig_in,
  input  logic              rd_done,
  output logic              trig_src,
  output logic              trig_slope,
  output logic              delay_sel,
  output logic              auto_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wave_ready,
  output logic              busy,
  output logic [15:0]       wave_number,
  output logic              timed_out
);

  localparam logic [7:0] CMD_ARM   = 8'h41;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STOP  = 8'h53;
  localparam logic [7:0] CMD_FORCE = 8'h46;
  localparam logic [7:0] CMD_TSRC  = 8'h54;
  localparam logic [7:0] CMD_TSLP  = 8'h4C;
  localparam logic [7:0] CMD_TDLY  = 8'h44;
  localparam logic [7:0] CMD_TAUTO = 8'h55;

  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LAST   = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLDOFF - 1);

  typedef enum logic [2:0] {IDLE, HOLD, WAIT_TRIG, CAPTURE, READY} state_t;

  // With no holdoff the delay line needs no filling, so arming skips HOLD.
  localparam state_t ARM_STATE = (HOLDOFF == 0) ? WAIT_TRIG : HOLD;

  state_t               state;
  logic [7:0]           cmd_prev;
  logic                 cont;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [TIMEOUT_W-1:0] to_cnt;

  logic cmd_new;
  logic c_stop, c_arm, c_force, c_tsrc, c_tslp, c_tdly, c_tauto;

  // Level-held command word: act only on the cycle it changes.
  assign cmd_new = (cmd != cmd_prev);
  assign c_stop  = cmd_new && (cmd == CMD_STOP);
  assign c_arm   = cmd_new && ((cmd == CMD_ARM) || (cmd == CMD_RUN));
  assign c_force = cmd_new && (cmd == CMD_FORCE);
  assign c_tsrc  = cmd_new && (cmd == CMD_TSRC);
  assign c_tslp  = cmd_new && (cmd == CMD_TSLP);
  assign c_tdly  = cmd_new && (cmd == CMD_TDLY);
  assign c_tauto = cmd_new && (cmd == CMD_TAUTO);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cmd_prev    <= 8'h00;
      cont        <= 1'b0;
      hold_cnt    <= '0;
      to_cnt      <= '0;
      trig_src    <= 1'b0;
      trig_slope  <= 1'b0;
      delay_sel   <= 1'b0;
      auto_en     <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wave_ready  <= 1'b0;
      busy        <= 1'b0;
      wave_number <= 16'h0000;
      timed_out   <= 1'b0;
    end else begin
      cmd_prev <= cmd;
      // Stop outranks trigger, timeout and readout completion.
      if (c_stop && (state != IDLE)) begin
        state      <= IDLE;
        wr_en      <= 1'b0;
        wave_ready <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE, READY: begin
            if (c_tsrc)  trig_src   <= ~trig_src;
            if (c_tslp)  trig_slope <= ~trig_slope;
            if (c_tdly)  delay_sel  <= ~delay_sel;
            if (c_tauto) auto_en    <= ~auto_en;
            if (c_arm) begin
              state      <= ARM_STATE;
              cont       <= (cmd == CMD_RUN);
              hold_cnt   <= '0;
              to_cnt     <= '0;
              wave_ready <= 1'b0;
              busy       <= 1'b1;
            end else if ((state == READY) && rd_done) begin
              state      <= cont ? ARM_STATE : IDLE;
              hold_cnt   <= '0;
              to_cnt     <= '0;
              wave_ready <= 1'b0;
              busy       <= cont;
            end
          end
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              state  <= WAIT_TRIG;
              to_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          WAIT_TRIG: begin
            if (trig_in || c_force) begin
              state     <= CAPTURE;
              wr_en     <= 1'b1;
              wr_addr   <= '0;
              timed_out <= 1'b0;
            end else if (auto_en && (to_cnt == TO_LAST)) begin
              state     <= CAPTURE;
              wr_en     <= 1'b1;
              wr_addr   <= '0;
              timed_out <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TIMEOUT_W'(1);
            end
          end
          CAPTURE: begin
            if (wr_addr == LAST_ADDR) begin
              state       <= READY;
              wr_en       <= 1'b0;
              wave_ready  <= 1'b1;
              wave_number <= wave_number + 16'd1;
            end else begin
              wr_addr <= wr_addr + ADDR_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            wr_en <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Central sequencer for the ADC acquisition datapath. Decodes the 8-bit ASCII command word from the Nios PIO and owns the trigger configuration bits: trigger source, trigger slope and delay-tap select. Arms the trigger, gates capture of one DEPTH-sample waveform into the waveform buffer, then holds the buffer stable until the Ethernet readout side signals completion. Sits between the Nios PIO/readout logic and the trigger, delay-mux and waveform-buffer blocks, all on the acquisition clock.

Parameters:
DEPTH, 1000, samples captured per waveform
ADDR_W, 10, buffer address width; 2**ADDR_W >= DEPTH
HOLDOFF, 100, cycles after arming before a trigger is accepted (fills delay line)
TIMEOUT_W, 24, width of auto-trigger timeout counter
TIMEOUT, 16777215, cycles in WAIT_TRIG before auto-trigger when auto_en=1

Ports:
clk  in  1  acquisition clock, all logic rising-edge
reset_n  in  1  synchronous active-low reset
cmd  in  8  ASCII command word from Nios PIO (level-held)
trig_in  in  1  trigger pulse from trigger block
rd_done  in  1  one-cycle pulse: readout of current waveform finished
trig_src  out  1  0 = channel A, 1 = channel B
trig_slope  out  1  0 = rising/level 7000, 1 = falling/level 9400
delay_sel  out  1  0 = tap 0, 1 = tap 99
auto_en  out  1  auto-trigger on timeout enabled
wr_en  out  1  buffer write strobe
wr_addr  out  ADDR_W  buffer write address
wave_ready  out  1  buffer holds complete waveform, safe to read
busy  out  1  state is not IDLE
wave_number  out  16  count of completed waveforms
timed_out  out  1  last waveform was auto-triggered

Behaviour:
- Reset (reset_n=0 at a clk edge): every output is 0 and state is IDLE; reset mid-capture abandons the waveform with no wave_number increment. The cmd_prev register is cleared to 0x00.
- Command decode: a command is accepted only on the cycle where cmd != cmd_prev (cmd_prev is registered every cycle). A held value therefore executes once; software writes 0x00 between repeats.
- Commands:
  - 'A' 0x41: arm single.
  - 'R' 0x52: arm continuous.
  - 'S' 0x53: stop.
  - 'F' 0x46: force trigger.
  - 'T' 0x54: toggle trig_src.
  - 'L' 0x4C: toggle trig_slope.
  - 'D' 0x44: toggle delay_sel.
  - 'U' 0x55: toggle auto_en.
  - Any other value is ignored.
- Toggles T/L/D/U take effect only in IDLE or READY; otherwise they are ignored. Toggled bits change the cycle after acceptance.
- States: IDLE, HOLD, WAIT_TRIG, CAPTURE, READY.
- IDLE: 'A' or 'R' -> HOLD, latch cont = (cmd=='R'), clear holdoff counter.
- HOLD: count HOLDOFF cycles, then -> WAIT_TRIG; trig_in is ignored in HOLD. With HOLDOFF=0, go directly to WAIT_TRIG.
- WAIT_TRIG: on trig_in=1 or 'F' -> CAPTURE with wr_addr=0, timed_out=0. If auto_en=1 and the timeout counter reaches TIMEOUT-1 -> CAPTURE with timed_out=1. The timeout counter clears on entry to WAIT_TRIG.
- CAPTURE: wr_en=1 on every cycle. The first write (addr 0) occurs in the first CAPTURE cycle, i.e. one cycle after the trigger is sampled. wr_addr increments 0..DEPTH-1. The cycle after the write to DEPTH-1: wr_en=0, go to READY, wave_number+1 (wraps 0xFFFF->0x0000), wave_ready=1. Exactly DEPTH writes per waveform.
- READY: wave_ready=1 and wr_en=0; wr_addr holds DEPTH-1.
  - rd_done with cont=1 -> HOLD.
  - rd_done with cont=0 -> IDLE.
  - wave_ready clears on the cycle the state leaves READY.
  - 'A'/'R' in READY re-arm directly (-> HOLD, cont updated) and discard pending readout.
- 'S' in any non-IDLE state -> IDLE next cycle; wr_en and wave_ready drop; no wave_number increment. 'S' takes priority over trig_in/timeout/rd_done in the same cycle.
- rd_done outside READY is ignored. trig_in outside WAIT_TRIG is ignored. 'A'/'R' in HOLD/WAIT_TRIG/CAPTURE are ignored.
- busy = (state != IDLE), registered.

Test Plan:
1. Reset, cmd 0x00->0x41, HOLDOFF=100, trig_in pulse 10 cycles after HOLD ends -> exactly 1000 wr_en cycles, addr 0..999, wave_ready=1, wave_number=1.
2. 'A' held 5000 cycles across a full capture plus rd_done -> only one waveform, return to IDLE, wave_number=1.
3. 'R', three triggers each followed by rd_done -> wave_number=3, state returns to HOLD after each rd_done; 'S' then -> IDLE, busy=0.
4. TIMEOUT=50, auto_en set via 'U', no trig_in -> capture starts 50 cycles after WAIT_TRIG entry, timed_out=1; with auto_en=0 no capture after 10000 cycles.
5. 'S' issued at wr_addr=500 in the same cycle as trig_in -> IDLE next cycle, wr_en=0, wave_number unchanged; 'T' during CAPTURE leaves trig_src unchanged, 'T' in IDLE flips it 0->1.
6. Preload wave_number=0xFFFF (via 65535 captures or forced state) plus one capture -> wave_number=0x0000; reset asserted mid-CAPTURE -> all outputs 0 next edge.
